// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul: iterative radix-4 Booth multiplier.
// Retires one Booth digit (two multiplier bits) per clock. It accepts operands
// through a valid/ready input port and returns the full 2*WIDTH-bit product
// through a valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens on the rising edge
// where valid && ready are both high. A producer holds its data stable while
// valid is high and no transfer has occurred. in_ready is combinational from
// state and out_ready only, so it never depends on in_valid. out_valid and p
// hold until out_ready is seen.
module booth_r4_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    // Operand width must be even and within 4..32.
    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("booth_r4_seq_mul: WIDTH must be even and in 4..32");
    end

    localparam int ITER = WIDTH / 2 + 1;        // Booth digits per product
    localparam int AW   = 2 * WIDTH + 4;        // accumulator width
    localparam int BW   = WIDTH + 3;            // extended multiplier plus b[-1]
    localparam int CW   = $clog2(ITER);         // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;       // running signed sum of Booth terms
    logic [AW-1:0]   mcand;     // multiplicand, pre-shifted by 2i for digit i
    logic [BW-1:0]   bq;        // multiplier window; bq[2:0] is the current digit
    logic [CW-1:0]   cnt;       // digit index i

    logic            accept;
    logic [AW-1:0]   mcand_init;
    logic [BW-1:0]   bq_init;
    logic [AW-1:0]   term;
    logic [AW-1:0]   acc_next;
    logic            last_iter;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CW'(ITER - 1));

    // Extend operands on capture. The signedness is folded into the extension
    // bits here, so later changes on signed_mode cannot affect this product.
    assign mcand_init = {{(AW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
    assign bq_init    = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};

    // Booth digit decode: select 0, +-A or +-2A from the current 3-bit window.
    always_comb begin
        term = '0;
        case (bq[2:0])
            3'b001, 3'b010: term = mcand;
            3'b011:         term = mcand << 1;
            3'b100:         term = -(mcand << 1);
            3'b101, 3'b110: term = -mcand;
            default:        term = '0;
        endcase
    end

    assign acc_next = acc + term;

    // Control FSM and datapath registers; all outputs except in_ready registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            bq        <= '0;
            cnt       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        cnt   <= '0;
                        mcand <= mcand_init;
                        bq    <= bq_init;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand << 2;
                    bq    <= {{2{bq[BW-1]}}, bq[BW-1:2]};
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        p         <= acc_next[2*WIDTH-1:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            // Hand-off and new accept on the same edge.
                            acc   <= '0;
                            cnt   <= '0;
                            mcand <= mcand_init;
                            bq    <= bq_init;
                            busy  <= 1'b1;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Testbench for booth_r4_seq_mul: directed vector table, backpressure,
// back-to-back and reset-abort sequences at WIDTH=8, and a random sweep at
// WIDTH=16 checked against a plain-arithmetic product model.
module tb_booth_r4_seq_mul;

    logic        clk;
    logic        rst_n;

    // WIDTH=8 instance
    logic        iv8, ir8, sm8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    // WIDTH=16 instance
    logic        iv16, ir16, sm16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int total;
    int bad;

    logic [15:0] exp8_q[$];
    logic [31:0] exp16_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    booth_r4_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8),
        .out_valid(ov8), .out_ready(or8),
        .p(p8), .busy(busy8)
    );

    booth_r4_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .signed_mode(sm16),
        .out_valid(ov16), .out_ready(or16),
        .p(p16), .busy(busy16)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Exact product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                            input bit smv, input int w);
        longint sa, sb, pr;
        logic [63:0] m;
        sa = longint'({32'd0, av});
        sb = longint'({32'd0, bv});
        if (smv) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        pr = sa * sb;
        m = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return pr & m;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] c[5];
        c = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 5) == 0) return c[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    // driver: one WIDTH=8 transaction, returns product and accept->out_valid latency
    task automatic do_mul8(input logic [7:0] av, input logic [7:0] bv, input bit smv,
                           output logic [15:0] pv, output int lat);
        int n;
        n = 0;
        while (!ir8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 64'(ir8), 64'd1);
        a8 = av; b8 = bv; sm8 = smv; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        // Perturb inputs after accept; the product must not change.
        iv8 = 1'b0; sm8 = ~smv; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        pv = p8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    initial begin
        logic [15:0] got;
        int          lat;
        int          n;
        int          cyc;
        int          idx;
        int          nrx;
        int          sent;
        int          rcv;
        bit          accepted;
        bit          take;
        bit          saw;
        int          acc_t[$];
        logic [7:0]  ba[3];
        logic [7:0]  bb[3];

        total = 0; bad = 0;
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 0;
        iv16 = 0; a16 = 0; b16 = 0; sm16 = 0; or16 = 0;

        vecs[0] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[5] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[6] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[7] = '{8'h80, 8'h01, 1'b0, 16'h0080};
        vecs[8] = '{8'h00, 8'h55, 1'b1, 16'h0000};
        vecs[9] = '{8'h7F, 8'h80, 1'b0, 16'h3F80};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_p", 64'(p8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_out_valid16", 64'(ov16), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(ir8), 64'd1);
        chk("rst_in_ready16", 64'(ir16), 64'd1);

        // directed vector table
        for (int i = 0; i < 10; i++) begin
            do_mul8(vecs[i].a, vecs[i].b, vecs[i].sm, got, lat);
            chk($sformatf("vec%0d_p", i), 64'(got), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
        end

        // backpressure: 7*9 held for 10 cycles
        a8 = 8'd7; b8 = 8'd9; sm8 = 1'b1; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(ov8), 64'd1);
            chk("bp_p", 64'(p8), 64'h003F);
            chk("bp_in_ready", 64'(ir8), 64'd0);
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        #1;
        chk("bp_in_ready_release", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("bp_out_valid_drop", 64'(ov8), 64'd0);
        chk("bp_p_kept", 64'(p8), 64'h003F);

        // back-to-back with in_valid and out_ready held high
        ba = '{8'd2, 8'hFC, 8'd100};
        bb = '{8'd3, 8'd6, 8'h9C};
        exp8_q.push_back(16'h0006);
        exp8_q.push_back(16'hFFE8);
        exp8_q.push_back(16'hD8F0);
        idx = 0; cyc = 0; nrx = 0;
        a8 = ba[0]; b8 = bb[0]; sm8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
        #1;
        while (nrx < 3 && cyc < 100) begin
            if (ov8 && or8) begin
                if (exp8_q.size() == 0) chk("b2b_extra", 64'(p8), 64'hDEAD);
                else chk("b2b_p", 64'(p8), 64'(exp8_q.pop_front()));
                nrx++;
            end
            accepted = iv8 && ir8;
            if (accepted) acc_t.push_back(cyc);
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                idx++;
                if (idx < 3) begin
                    a8 = ba[idx]; b8 = bb[idx];
                end else begin
                    iv8 = 1'b0;
                end
            end
        end
        or8 = 1'b0;
        chk("b2b_count", 64'(nrx), 64'd3);
        chk("b2b_accepts", 64'(acc_t.size()), 64'd3);
        if (acc_t.size() == 3) begin
            chk("b2b_gap0", 64'(acc_t[1] - acc_t[0]), 64'd6);
            chk("b2b_gap1", 64'(acc_t[2] - acc_t[1]), 64'd6);
        end

        // reset on the second CALC cycle
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_before", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov8), 64'd0);
        chk("abort_p", 64'(p8), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(ir8), 64'd1);
        or8 = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov8) saw = 1'b1;
        end
        or8 = 1'b0;
        chk("abort_no_stale", 64'(saw), 64'd0);
        chk("abort_busy_after", 64'(busy8), 64'd0);

        // random WIDTH=16 sweep with random gaps and stalls
        sent = 0; rcv = 0; cyc = 0;
        iv16 = 1'b0; or16 = 1'b1;
        #1;
        while (rcv < 1000 && cyc < 60000) begin
            take = ov16 && or16;
            if (take) begin
                if (exp16_q.size() == 0) chk("rnd_extra", 64'(p16), 64'hDEAD);
                else chk("rnd_p", 64'(p16), 64'(exp16_q.pop_front()));
                rcv++;
            end
            accepted = iv16 && ir16;
            if (accepted) begin
                exp16_q.push_back(32'(ref_mul(32'(a16), 32'(b16), sm16, 16)));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (accepted || !iv16) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    iv16 = 1'b1;
                    a16 = rnd16();
                    b16 = rnd16();
                    sm16 = 1'($urandom_range(0, 1));
                end else begin
                    iv16 = 1'b0;
                end
            end
            or16 = ($urandom_range(0, 3) != 0);
            #1;
        end
        chk("rnd_received", 64'(rcv), 64'd1000);
        chk("rnd_queue_empty", 64'(exp16_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
